rr_burst_sched: RTL and testbench
=================================

# rr_burst_sched

Weighted round-robin scheduler that shares one burst-oriented resource between REQCNT requesters. It extends the plain round-robin arbiter by holding a grant for up to a per-requester number of accepted beats, then rotating priority. It sits between the requester request lines and the shared resource's beat handshake, and drives the resource's select mux.

## Interface
- REQCNT, 16, number of requesters (≥2)
- WEIGHT_W, 4, width of each per-requester burst weight
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-low
- req_i  in  REQCNT  level request per requester; held until served or withdrawn
- weight_i  in  REQCNT*WEIGHT_W  max beats per grant for requester i (quasi-static config); 0 treated as 1
- beat_i  in  1  resource accepted one beat from the granted requester this cycle
- gnt_o  out  REQCNT  one-hot grant, all-zero when idle
- gnt_num_o  out  $clog2(REQCNT)  index of granted requester
- gnt_val_o  out  1  gnt_o/gnt_num_o valid
- last_o  out  1  combinational: current beat_i is the final beat of this grant (credit==1)

## Operation
- States: IDLE (no grant), GRANT (one requester owns resource).
- Pointer ptr: highest-priority index for next pick; reset 0.
- Pick: first i with req_i[i]=1 scanning ptr, ptr+1, … REQCNT-1, wrapping to ptr-1.
- IDLE -> GRANT when |req_i: register pick as gnt_num; load credit = max(weight_i[pick],1); ptr <= pick+1 (mod REQCNT).
- In GRANT, beat_i with credit>1: credit--; stay.
- Release when (beat_i && credit==1) or req_i[gnt_num]==0.
- On release: if any req_i bit is set (the releasing requester included, except when its request dropped), regrant on the same edge via the pick rule using the already-advanced ptr — no idle bubble. Otherwise -> IDLE.
- Lone requester: it is re-granted back-to-back with a fresh credit.
- weight_i is sampled only at grant load; changes mid-grant are ignored.
- beat_i in IDLE is ignored.
- Reset mid-grant: all outputs drop asynchronously; ptr is 0 after reset.

## Timing
- Reset values: gnt_o=0, gnt_num_o=0, gnt_val_o=0, last_o=0, state IDLE, credit 0.
- Grant latency: req_i rising in IDLE -> gnt_val_o=1 on the next rising edge (1 cycle).
- gnt_o, gnt_num_o and gnt_val_o are registered. last_o is the only combinational output.
- A grant of weight W with beat_i every cycle lasts exactly W cycles. The next grant is visible in the cycle after the last beat.
- Request withdrawn with no beat: grant drops 1 cycle after req_i falls.
- Fairness bound: a continuously requesting index waits at most the sum of the other requesters' weights in beat cycles, plus one cycle per intervening grant while beats stall.

## Structure
- Shared package rr_pkg:
  - state enum {IDLE, GRANT}
  - default REQCNT and WEIGHT_W constants
  - function clog2-safe index width
- Sub-module rr_ptr_pick: combinational rotate/priority/rotate-back picker (req vector and ptr in; index and found out). Reusable by the plain arbiter.
- Top holds the FSM, ptr, credit counter, grant registers.

## Test plan
- Reset with req_i=16'hFFFF asserted → all outputs 0. After release, first grant is index 0 one cycle later.
- All 16 requesting, weights all 2, beat_i=1 → grants 0,0,1,1,…,15,15,0 with no gap. last_o is high on every second beat.
- req_i=16'h0001 only, weight 3, continuous beats → gnt_num_o=0 stays asserted, last_o high every 3rd cycle, gnt_val_o never drops.
- Grant to index 5 (weight 8), drop req_i[5] after 2 beats while req_i[9]=1 → next cycle gnt_num_o=9. ptr skips 6–8.
- weight_i[3]=0 → index 3 receives exactly 1 beat per grant.
- Random req_i and beat_i for 10k cycles, weights 1..15 → one-hot gnt_o, no grant to a non-requester, max wait ≤ fairness bound.

Source files
------------

// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin schedulers: state encoding,
// default sizing and a helper for index widths that stays legal for tiny counts.
package rr_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } rr_state_t;

    localparam int RR_REQCNT   = 16;
    localparam int RR_WEIGHT_W = 4;

    // Never returns 0, so an index bus always has at least one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_ptr_pick.sv
// Combinational rotating priority picker: first set request at or after ptr,
// wrapping around. Shared with the plain round-robin arbiter.
module rr_ptr_pick
    import rr_pkg::*;
#(
    parameter int N  = RR_REQCNT,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [IW:0]    sum;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the
    // offset back into an absolute index (ptr + offset, modulo N).
    always_comb begin
        doubled = {req, req} >> ptr;
        rotated = doubled[N-1:0];
        found   = 1'b0;
        sum     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (IW+1)'(k);
            end
        end
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        idx = sum[IW-1:0];
    end

endmodule

// File: rtl/rr_burst_sched.sv
// Weighted round-robin burst scheduler: a grant is held for up to weight beats
// (or until the request drops), then priority rotates past the last winner.
module rr_burst_sched
    import rr_pkg::*;
#(
    parameter  int REQCNT   = RR_REQCNT,
    parameter  int WEIGHT_W = RR_WEIGHT_W,
    localparam int IW       = idx_w(REQCNT)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [REQCNT-1:0]            req_i,
    input  logic [REQCNT*WEIGHT_W-1:0]   weight_i,
    input  logic                         beat_i,
    output logic [REQCNT-1:0]            gnt_o,
    output logic [IW-1:0]                gnt_num_o,
    output logic                         gnt_val_o,
    output logic                         last_o
);

    rr_state_t           state;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       pick;
    logic [IW-1:0]       next_ptr;
    logic                found;
    logic [WEIGHT_W-1:0] credit;
    logic [WEIGHT_W-1:0] pick_weight;
    logic [WEIGHT_W-1:0] load_credit;
    logic                hold_req;
    logic                release_now;

    rr_ptr_pick #(
        .N  (REQCNT),
        .IW (IW)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr),
        .idx   (pick),
        .found (found)
    );

    // A zero weight would otherwise load a grant that can never finish.
    assign pick_weight = weight_i[pick*WEIGHT_W +: WEIGHT_W];
    assign load_credit = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;
    assign next_ptr    = (pick == IW'(REQCNT - 1)) ? '0 : pick + 1'b1;

    assign hold_req    = req_i[gnt_num_o];
    assign last_o      = (state == GRANT) && beat_i && (credit == WEIGHT_W'(1));
    assign release_now = (state == GRANT) && (!hold_req || last_o);

    // Releasing and re-granting share one edge, so back-to-back bursts have
    // no idle bubble; the picker already sees the advanced pointer.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            ptr       <= '0;
            credit    <= '0;
            gnt_o     <= '0;
            gnt_num_o <= '0;
            gnt_val_o <= 1'b0;
        end else begin
            if ((state == IDLE || release_now) && found) begin
                state     <= GRANT;
                ptr       <= next_ptr;
                credit    <= load_credit;
                gnt_num_o <= pick;
                gnt_val_o <= 1'b1;
                gnt_o     <= REQCNT'(1) << pick;
            end else if (release_now) begin
                state     <= IDLE;
                credit    <= '0;
                gnt_o     <= '0;
                gnt_val_o <= 1'b0;
            end else if (state == GRANT && beat_i) begin
                credit    <= credit - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rr_burst_sched.sv
// Bench for rr_burst_sched: directed scenarios with literal expectations plus a
// long randomized run compared every cycle against a queue-free rule model.
module tb_rr_burst_sched;

    localparam int N  = 16;
    localparam int W  = 4;
    localparam int IW = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [N-1:0]      req_i = '0;
    logic [N*W-1:0]    weight_i = '0;
    logic              beat_i = 1'b0;
    logic [N-1:0]      gnt_o;
    logic [IW-1:0]     gnt_num_o;
    logic              gnt_val_o;
    logic              last_o;

    int n_cmp = 0;
    int n_bad = 0;

    int wt [N];

    // Model: who owns the resource, how many beats remain, where priority starts.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_left  = 0;
    int m_ptr   = 0;

    bit fair_en  = 1'b0;
    int wb [N];
    bit prev_val = 1'b0;
    int prev_num = 0;

    rr_burst_sched #(
        .REQCNT   (N),
        .WEIGHT_W (W)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .weight_i  (weight_i),
        .beat_i    (beat_i),
        .gnt_o     (gnt_o),
        .gnt_num_o (gnt_num_o),
        .gnt_val_o (gnt_val_o),
        .last_o    (last_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic b);
        @(negedge clk_i);
        rst_i  = 1'b1;
        req_i  = r;
        beat_i = b;
        #2;
    endtask

    task automatic doReset(input logic [N-1:0] r);
        @(negedge clk_i);
        rst_i  = 1'b0;
        req_i  = r;
        beat_i = 1'b0;
        #2;
    endtask

    task automatic setWeights();
        for (int i = 0; i < N; i++) begin
            weight_i[i*W +: W] = W'(wt[i]);
        end
    endtask

    function automatic int effWeight(input int i);
        return (wt[i] == 0) ? 1 : wt[i];
    endfunction

    // Hand the resource to the first requester found scanning from m_ptr.
    task automatic modelPick();
        bit got;
        int idx;
        got = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!got && req_i[idx]) begin
                got     = 1'b1;
                m_owner = idx;
                m_left  = effWeight(idx);
                m_ptr   = (idx + 1) % N;
            end
        end
        m_busy = got;
    endtask

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_left  = 0;
            m_ptr   = 0;
        end else if (m_busy) begin
            if (!req_i[m_owner] || (beat_i && m_left == 1)) begin
                modelPick();
            end else if (beat_i) begin
                m_left--;
            end
        end else begin
            modelPick();
        end
    end

    // Every cycle, mid-way between edges, compare outputs with the model and
    // track beats spent on others while each requester waits.
    always @(negedge clk_i) begin
        logic [N-1:0] exp_gnt;
        bit           own;
        int           bound;
        #2;
        exp_gnt = m_busy ? (N'(1) << m_owner) : '0;
        checkOutput("gnt_val", 32'(gnt_val_o), 32'(m_busy));
        checkOutput("gnt_onehot", 32'(gnt_o), 32'(exp_gnt));
        checkOutput("last", 32'(last_o), 32'(m_busy && beat_i && m_left == 1));
        if (m_busy) begin
            checkOutput("gnt_num", 32'(gnt_num_o), 32'(m_owner));
        end else if (!rst_i) begin
            checkOutput("gnt_num_rst", 32'(gnt_num_o), 32'd0);
        end
        if (fair_en) begin
            for (int i = 0; i < N; i++) begin
                own = gnt_val_o && (int'(gnt_num_o) == i);
                if (own && !(prev_val && prev_num == i)) begin
                    bound = 0;
                    for (int j = 0; j < N; j++) begin
                        if (j != i) bound += effWeight(j);
                    end
                    n_cmp++;
                    if (wb[i] > bound) begin
                        n_bad++;
                        $display("[TB] FAIL fairness idx %0d: waited %0d beats, limit %0d", i, wb[i], bound);
                    end
                    wb[i] = 0;
                end else if (!req_i[i]) begin
                    wb[i] = 0;
                end else if (!own && gnt_val_o && beat_i) begin
                    wb[i]++;
                end
            end
        end
        prev_val = gnt_val_o;
        prev_num = int'(gnt_num_o);
    end

    initial begin
        logic [N-1:0] r;

        // Reset with everyone requesting, then weight-2 rotation 0,0,1,1,...
        for (int i = 0; i < N; i++) wt[i] = 2;
        setWeights();
        doReset(16'hFFFF);
        checkOutput("rst_gnt", 32'(gnt_o), 32'd0);
        checkOutput("rst_val", 32'(gnt_val_o), 32'd0);
        checkOutput("rst_num", 32'(gnt_num_o), 32'd0);
        checkOutput("rst_last", 32'(last_o), 32'd0);
        applyStimulus(16'hFFFF, 1'b1);
        checkOutput("release_idle", 32'(gnt_val_o), 32'd0);
        for (int c = 0; c < 34; c++) begin
            applyStimulus(16'hFFFF, 1'b1);
            checkOutput("w2_num", 32'(gnt_num_o), 32'((c / 2) % N));
            checkOutput("w2_val", 32'(gnt_val_o), 32'd1);
            checkOutput("w2_last", 32'(last_o), 32'(c % 2));
        end

        // Reset landing mid-grant must clear outputs without a clock edge.
        doReset(16'hFFFF);
        checkOutput("midgrant_rst_val", 32'(gnt_val_o), 32'd0);
        checkOutput("midgrant_rst_gnt", 32'(gnt_o), 32'd0);

        // Lone requester with weight 3 is re-granted back-to-back.
        wt[0] = 3;
        setWeights();
        doReset(16'h0001);
        applyStimulus(16'h0001, 1'b1);
        for (int c = 0; c < 9; c++) begin
            applyStimulus(16'h0001, 1'b1);
            checkOutput("lone_num", 32'(gnt_num_o), 32'd0);
            checkOutput("lone_val", 32'(gnt_val_o), 32'd1);
            checkOutput("lone_last", 32'(last_o), 32'(c % 3 == 2));
        end

        // Index 5 (weight 8) withdraws after two beats; 9 follows, 6-8 skipped.
        wt[5] = 8;
        setWeights();
        doReset(16'h0220);
        applyStimulus(16'h0220, 1'b0);
        applyStimulus(16'h0220, 1'b1);
        checkOutput("w8_first", 32'(gnt_num_o), 32'd5);
        applyStimulus(16'h0220, 1'b1);
        checkOutput("w8_second", 32'(gnt_num_o), 32'd5);
        applyStimulus(16'h0200, 1'b0);
        checkOutput("w8_drop_hold", 32'(gnt_num_o), 32'd5);
        applyStimulus(16'h0200, 1'b0);
        checkOutput("w8_next_num", 32'(gnt_num_o), 32'd9);
        checkOutput("w8_next_val", 32'(gnt_val_o), 32'd1);

        // Zero weight behaves as one beat per grant.
        wt[3] = 0;
        setWeights();
        doReset(16'h0008);
        applyStimulus(16'h0008, 1'b1);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(16'h0008, 1'b1);
            checkOutput("w0_num", 32'(gnt_num_o), 32'd3);
            checkOutput("w0_last", 32'(last_o), 32'd1);
        end

        // Randomized traffic with sticky requests and stalling beats.
        for (int i = 0; i < N; i++) wt[i] = $urandom_range(1, 15);
        setWeights();
        doReset('0);
        for (int i = 0; i < N; i++) wb[i] = 0;
        r = '0;
        applyStimulus(r, 1'b0);
        fair_en = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
            end
            applyStimulus(r, $urandom_range(0, 3) != 0);
        end
        fair_en = 1'b0;
        applyStimulus('0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
